// File: rtl/clock_divider_prog.sv
// Programmable clock divider: runtime-loadable divisor, ~50% duty clk_out_o,
// one-cycle tick_o at the end of each period; divisor changes land only on period boundaries.
module clock_divider_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             div_load_i,
  input  logic [WIDTH-1:0] div_in_i,
  output logic             div_ack_o,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic [WIDTH-1:0] count_o
);

  // state    | meaning
  // ST_STOP  | active divisor is 0; outputs parked low, waiting for a new divisor
  // ST_RUN   | active divisor >= 2; count walks 0..cur-1 on enabled edges
  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_CNT = (DEFAULT_DIV == 0) ? '0 : WIDTH'(DEFAULT_DIV - 1);
  localparam state_t           RST_ST  = (DEFAULT_DIV == 0) ? ST_STOP : ST_RUN;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             div_ack_q, div_ack_d;

  logic [WIDTH-1:0] cur_last;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] next_cur;
  logic             wrap;

  // High phase length is ceil(d/2); computed without widening so d = 2**WIDTH-1 is safe.
  function automatic logic [WIDTH-1:0] hi_of(input logic [WIDTH-1:0] d);
    return d - (d >> 1);
  endfunction

  assign cur_last = cur_q - ONE;
  assign cnt_inc  = count_q + ONE;
  assign wrap     = (count_q == cur_last);
  assign next_cur = pend_valid_q ? pend_q : cur_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= RST_ST;
      cur_q        <= RST_DIV;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      count_q      <= RST_CNT;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      div_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      count_q      <= count_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      div_ack_q    <= div_ack_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    count_d      = count_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    div_ack_d    = 1'b0;

    case (state_q)
      ST_STOP: begin
        count_d   = '0;
        clk_out_d = 1'b0;
        // Leaving STOP ignores enable; count is parked at cur-1 so the first enabled edge wraps to 0.
        if (pend_valid_q) begin
          cur_d        = pend_q;
          pend_valid_d = 1'b0;
          div_ack_d    = 1'b1;
          if (pend_q != '0) begin
            count_d = pend_q - ONE;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (enable_i) begin
          if (wrap) begin
            count_d   = '0;
            clk_out_d = (hi_of(next_cur) != '0);
            tick_d    = (next_cur == ONE);
            if (pend_valid_q) begin
              cur_d        = pend_q;
              pend_valid_d = 1'b0;
              div_ack_d    = 1'b1;
              if (pend_q == '0) begin
                state_d = ST_STOP;
              end
            end
          end else begin
            count_d   = cnt_inc;
            clk_out_d = (cnt_inc < hi_of(cur_q));
            tick_d    = (cnt_inc == cur_last);
          end
        end
      end

      default: begin
        state_d = RST_ST;
      end
    endcase

    // Capture after the wrap so a load coinciding with an apply becomes the next pending value.
    if (div_load_i) begin
      pend_d       = (div_in_i == ONE) ? TWO : div_in_i;
      pend_valid_d = 1'b1;
    end
  end

  assign div_ack_o = div_ack_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign count_o   = count_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: a driver issues per-cycle vectors and queues
// hand-computed expectations; a monitor pops and compares after every rising edge.
module tb_clock_divider_prog;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       div_load;
  logic [7:0] div_in;
  logic       div_ack;
  logic       clk_out;
  logic       tick;
  logic [7:0] count;

  typedef struct {
    int         idx;
    logic       clk_out;
    logic       tick;
    logic [7:0] count;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_n   = 0;
  bit   done     = 0;

  clock_divider_prog #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .div_load_i (div_load),
    .div_in_i   (div_in),
    .div_ack_o  (div_ack),
    .clk_out_o  (clk_out),
    .tick_o     (tick),
    .count_o    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic l, input logic [7:0] d,
                      input logic ec, input logic et, input logic [7:0] ecnt, input logic ea);
    exp_t x;
    @(negedge clk);
    reset    = r;
    enable   = e;
    div_load = l;
    div_in   = d;
    step_n++;
    x.idx     = step_n;
    x.clk_out = ec;
    x.tick    = et;
    x.count   = ecnt;
    x.ack     = ea;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if (clk_out !== x.clk_out) begin
        failures++;
        $display("FAIL step%0d clk_out got=%b want=%b", x.idx, clk_out, x.clk_out);
      end
      checks++;
      if (tick !== x.tick) begin
        failures++;
        $display("FAIL step%0d tick got=%b want=%b", x.idx, tick, x.tick);
      end
      checks++;
      if (count !== x.count) begin
        failures++;
        $display("FAIL step%0d count got=%0d want=%0d", x.idx, count, x.count);
      end
      checks++;
      if (div_ack !== x.ack) begin
        failures++;
        $display("FAIL step%0d div_ack got=%b want=%b", x.idx, div_ack, x.ack);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_in = 8'd0;
    //    rst en ld din   clk tick cnt ack
    // reset values, DEFAULT_DIV=2
    step(1, 0, 0, 8'd0,  0, 0, 8'd1, 0);
    step(1, 1, 0, 8'd0,  0, 0, 8'd1, 0);
    // divide by 2
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd1, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd1, 0);
    // load 5 on a wrap with nothing pending: not applied until the following wrap
    step(0, 1, 1, 8'd5,  1, 0, 8'd0, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd1, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 1);
    step(0, 1, 0, 8'd0,  1, 0, 8'd1, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd2, 0);
    step(0, 1, 0, 8'd0,  0, 0, 8'd3, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd4, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd1, 0);
    // freeze 7 cycles at count 1
    for (int i = 0; i < 7; i++) step(0, 0, 0, 8'd0, 1, 0, 8'd1, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd2, 0);
    step(0, 1, 0, 8'd0,  0, 0, 8'd3, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd4, 0);
    // load 0: stops at the next wrap
    step(0, 1, 1, 8'd0,  1, 0, 8'd0, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd1, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd2, 0);
    step(0, 1, 0, 8'd0,  0, 0, 8'd3, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd4, 0);
    step(0, 1, 0, 8'd0,  0, 0, 8'd0, 1);
    step(0, 1, 0, 8'd0,  0, 0, 8'd0, 0);
    // load 4 while stopped; applied on the next edge even with enable low
    step(0, 0, 1, 8'd4,  0, 0, 8'd0, 0);
    step(0, 0, 0, 8'd0,  0, 0, 8'd3, 1);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd1, 0);
    step(0, 1, 0, 8'd0,  0, 0, 8'd2, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd3, 0);
    // load 1 -> clamped to 2
    step(0, 1, 1, 8'd1,  1, 0, 8'd0, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd1, 0);
    step(0, 1, 0, 8'd0,  0, 0, 8'd2, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd3, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 1);
    step(0, 1, 0, 8'd0,  0, 1, 8'd1, 0);
    // load 9 then 6 before the wrap: last wins, single ack
    step(0, 1, 1, 8'd9,  1, 0, 8'd0, 0);
    step(0, 1, 1, 8'd6,  0, 1, 8'd1, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 1);
    step(0, 1, 0, 8'd0,  1, 0, 8'd1, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd2, 0);
    step(0, 1, 0, 8'd0,  0, 0, 8'd3, 0);
    step(0, 1, 0, 8'd0,  0, 0, 8'd4, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd5, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 0);
    // reset with 7 pending at count 3: discarded, no ack, back to divide by 2
    step(0, 1, 1, 8'd7,  1, 0, 8'd1, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd2, 0);
    step(0, 1, 0, 8'd0,  0, 0, 8'd3, 0);
    step(1, 1, 0, 8'd0,  0, 0, 8'd1, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd1, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd1, 0);
    // load at a wrap with 3 pending: 3 applies now, 4 waits for the next wrap
    step(0, 1, 1, 8'd3,  1, 0, 8'd0, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd1, 0);
    step(0, 1, 1, 8'd4,  1, 0, 8'd0, 1);
    step(0, 1, 0, 8'd0,  1, 0, 8'd1, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd2, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 1);
    step(0, 1, 0, 8'd0,  1, 0, 8'd1, 0);
    step(0, 1, 0, 8'd0,  0, 0, 8'd2, 0);
    step(0, 1, 0, 8'd0,  0, 1, 8'd3, 0);
    step(0, 1, 0, 8'd0,  1, 0, 8'd0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout steps=%0d pending=%0d", step_n, exp_q.size());
      $fatal(1, "timeout");
    end
  end

endmodule
